// File: rtl/fcs_append.sv
// Transmit FCS stage: forwards the frame dibits, zero-pads to the minimum length,
// appends the CRC-32 FCS, then holds an inter-frame gap, dropping frames that arrive meanwhile.
module fcs_append #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_CYCLES      = 48,
    parameter int CNT_W           = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       done,
    output logic       drop
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_DIBITS = CNT_W'(MIN_FRAME_BYTES * 4);
    localparam int               GAP_W      = $clog2(IFG_CYCLES + 2);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(IFG_CYCLES);
    localparam logic [31:0]      POLY       = 32'hEDB88320;
    localparam logic [31:0]      CRC_INIT   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FCS,
        GAP
    } state_t;

    state_t           state;
    logic [31:0]      crc;
    logic [CNT_W-1:0] count;
    logic [3:0]       fcs_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             discard;
    logic             axiiv_q;

    logic             rise;
    logic             tail_busy;
    logic             need_pad;
    logic [CNT_W-1:0] count_inc;
    logic [31:0]      fcs_val;

    // Reflected CRC-32, wire-earlier bit (d[0]) first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign rise      = axiiv && !axiiv_q;
    assign tail_busy = (state == PAD) || (state == FCS) || (state == GAP);
    assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;
    assign fcs_val   = ~crc;

    // A saturated count means an over-long frame: never pad it.
    assign need_pad  = (count != CNT_MAX) &&
                       ((count < MIN_DIBITS) || (count[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            crc     <= CRC_INIT;
            count   <= '0;
            fcs_idx <= '0;
            gap_cnt <= '0;
            discard <= 1'b0;
            axiiv_q <= 1'b0;
            axiov   <= 1'b0;
            axiod   <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            axiiv_q <= axiiv;
            drop    <= rise && tail_busy;
            discard <= axiiv && (discard || (rise && tail_busy));
            axiov   <= 1'b0;
            axiod   <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (axiiv && !discard) begin
                        axiov <= 1'b1;
                        axiod <= axiid;
                        crc   <= crc_step(CRC_INIT, axiid);
                        count <= {{(CNT_W-1){1'b0}}, 1'b1};
                        state <= DATA;
                    end
                end
                DATA, PAD: begin
                    if (state == DATA && axiiv) begin
                        axiov <= 1'b1;
                        axiod <= axiid;
                        crc   <= crc_step(crc, axiid);
                        count <= count_inc;
                    end else if (need_pad) begin
                        busy  <= 1'b1;
                        axiov <= 1'b1;
                        axiod <= 2'b00;
                        crc   <= crc_step(crc, 2'b00);
                        count <= count_inc;
                        state <= PAD;
                    end else begin
                        // crc now carries the not-yet-sent FCS bits
                        busy    <= 1'b1;
                        axiov   <= 1'b1;
                        axiod   <= fcs_val[1:0];
                        crc     <= fcs_val >> 2;
                        fcs_idx <= 4'd1;
                        state   <= FCS;
                    end
                end
                FCS: begin
                    busy    <= 1'b1;
                    axiov   <= 1'b1;
                    axiod   <= crc[1:0];
                    crc     <= crc >> 2;
                    fcs_idx <= fcs_idx + 1'b1;
                    if (fcs_idx == 4'd15) begin
                        done    <= 1'b1;
                        crc     <= CRC_INIT;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        busy    <= 1'b1;
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcs_append.sv
// Bench for fcs_append: two instances (no minimum, 60-byte minimum) checked
// every cycle against a frame-level model of pad, FCS, gap and drop timing.
module tb_fcs_append;

    localparam int IFG  = 48;
    localparam int CW   = 13;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        int         e;
        logic [1:0] d;
        logic       dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic [1:0] ov, dn, dr, bz;
    logic [1:0] od0, od1;

    exp_t        eq0[$];
    exp_t        eq1[$];
    int          dq0[$];
    int          dq1[$];
    int          min4[2]      = '{0, 240};
    int          next_free[2] = '{0, 0};
    int          busy_lo[2]   = '{-1, -1};
    int          busy_hi[2]   = '{-1, -1};
    int          cap_cnt[2]   = '{0, 0};
    int          last_len[2]  = '{0, 0};
    int          drops_seen[2] = '{0, 0};
    logic [31:0] cap_sh[2];
    logic [31:0] last_fcs[2];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    always #10 clk = ~clk;

    fcs_append #(.MIN_FRAME_BYTES(0), .IFG_CYCLES(IFG), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(ov[0]), .axiod(od0), .busy(bz[0]), .done(dn[0]), .drop(dr[0])
    );

    fcs_append #(.MIN_FRAME_BYTES(60), .IFG_CYCLES(IFG), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(ov[1]), .axiod(od1), .busy(bz[1]), .done(dn[1]), .drop(dr[1])
    );

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
        end
    endtask

    // Textbook bit-serial CRC-32 over the wire bit sequence.
    function automatic logic [31:0] crc32(input logic [1:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (d[k]) begin
            for (int b = 0; b < 2; b++) begin
                c = c ^ {31'b0, d[k][b]};
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic push_byte(inout logic [1:0] q[$], input logic [7:0] b);
        q.push_back(b[1:0]);
        q.push_back(b[3:2]);
        q.push_back(b[5:4]);
        q.push_back(b[7:6]);
    endtask

    task automatic rand_bytes(output logic [1:0] q[$], input int n);
        q = {};
        for (int k = 0; k < n; k++) push_byte(q, 8'($urandom));
    endtask

    task automatic model_start(input int i, input int s, input logic [1:0] f[$]);
        logic [1:0]  o[$];
        logic [31:0] fcs;
        exp_t        x;
        int          len;
        int          p;
        len = f.size();
        if (s < next_free[i]) begin
            if (i == 0) dq0.push_back(s);
            else dq1.push_back(s);
            return;
        end
        o = f;
        if (len < MAXC) begin
            p = ((len + 3) / 4) * 4;
            if (p < min4[i]) p = min4[i];
            while (o.size() < p) o.push_back(2'b00);
        end
        fcs = crc32(o);
        for (int k = 0; k < 16; k++) o.push_back(fcs[2*k +: 2]);
        for (int k = 0; k < o.size(); k++) begin
            x.e  = s + k;
            x.d  = o[k];
            x.dn = (k == o.size() - 1);
            if (i == 0) eq0.push_back(x);
            else eq1.push_back(x);
        end
        busy_lo[i]   = s + len;
        busy_hi[i]   = s + o.size() + IFG - 1;
        next_free[i] = s + o.size() + IFG + 1;
    endtask

    task automatic model_reset();
        eq0 = {};
        eq1 = {};
        dq0 = {};
        dq1 = {};
        for (int i = 0; i < 2; i++) begin
            next_free[i] = 0;
            busy_lo[i]   = -1;
            busy_hi[i]   = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] f[$], output int s);
        s = cyc + 1;
        model_start(0, s, f);
        model_start(1, s, f);
        foreach (f[k]) begin
            axiiv = 1'b1;
            axiid = f[k];
            tick();
        end
        axiiv = 1'b0;
        axiid = 2'b00;
        tick();
    endtask

    task automatic cmp_inst(input int i);
        exp_t       x;
        logic       ev, edn, edr, eb;
        logic [1:0] ed, odv;
        int         tmp;
        odv = (i == 0) ? od0 : od1;
        if (rst) begin
            check("rst_out", i, 32'({ov[i], odv, bz[i], dn[i], dr[i]}), 32'd0);
            cap_cnt[i] = 0;
            return;
        end
        ev = 1'b0; ed = 2'b00; edn = 1'b0; edr = 1'b0;
        if (i == 0) begin
            if (eq0.size() > 0 && eq0[0].e == cyc) begin
                x = eq0.pop_front(); ev = 1'b1; ed = x.d; edn = x.dn;
            end
            if (dq0.size() > 0 && dq0[0] == cyc) begin
                tmp = dq0.pop_front(); edr = 1'b1;
            end
        end else begin
            if (eq1.size() > 0 && eq1[0].e == cyc) begin
                x = eq1.pop_front(); ev = 1'b1; ed = x.d; edn = x.dn;
            end
            if (dq1.size() > 0 && dq1[0] == cyc) begin
                tmp = dq1.pop_front(); edr = 1'b1;
            end
        end
        eb = (cyc >= busy_lo[i]) && (cyc <= busy_hi[i]);
        check("axiov", i, 32'(ov[i]), 32'(ev));
        check("axiod", i, 32'(odv), 32'(ed));
        check("done", i, 32'(dn[i]), 32'(edn));
        check("drop", i, 32'(dr[i]), 32'(edr));
        check("busy", i, 32'(bz[i]), 32'(eb));
        if (dr[i]) drops_seen[i]++;
        if (ov[i]) begin
            cap_sh[i] = {odv, cap_sh[i][31:2]};
            cap_cnt[i]++;
            if (dn[i]) begin
                last_len[i] = cap_cnt[i];
                last_fcs[i] = cap_sh[i];
                cap_cnt[i]  = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) cmp_inst(i);
    end

    initial begin
        logic [1:0]  f[$];
        logic [1:0]  f60[$];
        logic [31:0] fcs60;
        string       str;
        int          s, s2, d0, d1, n, ex, gap;

        repeat (3) tick();
        check("reset_state", 0, 32'({ov, bz, dn, dr, od0, od1}), 32'd0);
        rst = 1'b0;
        tick();

        // Model pins against known CRC-32 check values.
        str = "123456789";
        f = {};
        for (int k = 0; k < 9; k++) push_byte(f, str[k]);
        check("pin_crc_123456789", 0, crc32(f), 32'hCBF43926);
        begin
            logic [1:0] fa[$];
            push_byte(fa, 8'h61);
            check("pin_crc_a", 0, crc32(fa), 32'hE8B7BE43);
        end

        send(f, s);
        repeat (300) tick();
        check("t1_len", 0, 32'(last_len[0]), 32'd52);
        check("t1_fcs", 0, last_fcs[0], 32'hCBF43926);
        check("t1_len_pad", 1, 32'(last_len[1]), 32'd256);

        rand_bytes(f, 14);
        send(f, s);
        repeat (300) tick();
        check("t2_len", 1, 32'(last_len[1]), 32'd256);
        check("t2_len_nopad", 0, 32'(last_len[0]), 32'd72);

        rand_bytes(f60, 60);
        send(f60, s);
        while (cyc < s + 255 + IFG) tick();
        check("t3_busy_last", 1, 32'(bz[1]), 32'd1);
        tick();
        check("t3_busy_drop", 1, 32'(bz[1]), 32'd0);
        check("t3_len", 1, 32'(last_len[1]), 32'd256);
        check("t3_len0", 0, 32'(last_len[0]), 32'd256);
        fcs60 = last_fcs[1];
        repeat (5) tick();

        d0 = drops_seen[0];
        d1 = drops_seen[1];
        send(f60, s);
        while (cyc < s + 256 + 4) tick();
        rand_bytes(f, 20);
        send(f, s2);
        repeat (100) tick();
        check("t4_drops", 0, 32'(drops_seen[0] - d0), 32'd1);
        check("t4_drops", 1, 32'(drops_seen[1] - d1), 32'd1);
        rand_bytes(f, 30);
        send(f, s);
        repeat (320) tick();
        check("t4_next_len", 1, 32'(last_len[1]), 32'd256);
        check("t4_next_len0", 0, 32'(last_len[0]), 32'd136);

        send(f60, s);
        while (cyc < s + 247) tick();
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_axiov", 0, 32'({ov[0], bz[0]}), 32'd0);
        check("t5_axiov", 1, 32'({ov[1], bz[1]}), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        send(f60, s);
        repeat (320) tick();
        check("t5_fcs", 0, last_fcs[0], fcs60);
        check("t5_fcs", 1, last_fcs[1], fcs60);

        for (int r = 0; r < 30; r++) begin
            n  = $urandom_range(14, 200);
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            rand_bytes(f, n);
            for (int k = 0; k < ex; k++) f.push_back(2'($urandom));
            send(f, s);
            gap = $urandom_range(1, 350);
            repeat (gap) tick();
        end
        repeat (400) tick();

        f = {};
        for (int k = 0; k < MAXC + 2; k++) f.push_back(2'($urandom));
        send(f, s);
        repeat (400) tick();
        check("long_len", 1, 32'(last_len[1]), 32'(MAXC + 2 + 16));

        check("drain", 0, 32'(eq0.size() + dq0.size()), 32'd0);
        check("drain", 1, 32'(eq1.size() + dq1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
